// File: rtl/simon_led_sched.sv
// Shared 4-LED bank scheduler for the Simon game: fixed-priority grants with hold and dark gap.
// Optional attract-mode chase when SIMON_LED_ATTRACT_EN is defined.
module simon_led_sched #(
    parameter int N_LED      = 4,
    parameter int MIN_HOLD   = 4,
    parameter int GAP_CYC    = 2,
    parameter int BLINK_HALF = 8,
    parameter int ATTR_IDLE  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fini,
    input  logic             lightAllSl,
    input  logic             lightRndSl,
    input  logic [N_LED-1:0] rndLed,
    input  logic             simonsTurn,
    input  logic [N_LED-1:0] switches,
    output logic [N_LED-1:0] led,
    output logic             grantVld,
    output logic [1:0]       grantId,
    output logic             attractOn
);

    typedef enum logic [1:0] {IDLE, OWN, GAP, ATTRACT} state_t;

    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [N_LED-1:0] ONES = '1;

    state_t           state;
    logic [HW-1:0]    holdCnt;
    logic [GW-1:0]    gapCnt;
    logic [BW-1:0]    blinkCnt;
    logic             blinkOn;
    logic [N_LED-1:0] patLatch;

`ifdef SIMON_LED_ATTRACT_EN
    localparam int IW = (ATTR_IDLE > 1) ? $clog2(ATTR_IDLE) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(ATTR_IDLE - 1);
    logic [IW-1:0] idleCnt;
`else
    assign attractOn = 1'b0 & (ATTR_IDLE < 0);
`endif

    logic [3:0]       req;
    logic [3:0]       lowMask;
    logic [1:0]       winId;
    logic [N_LED-1:0] winPat;
    logic [N_LED-1:0] ownPat;
    logic             ownReq;
    logic             higherReq;
    logic             failOwn;
    logic             holdDone;
    logic             arbPoint;
    logic             grantNow;

    function automatic logic [N_LED-1:0] srcPat(
        input logic [1:0]       id,
        input logic [N_LED-1:0] rl,
        input logic [N_LED-1:0] sw
    );
        case (id)
            2'd2:    return rl;
            2'd3:    return sw;
            default: return ONES;
        endcase
    endfunction

    assign req = {!simonsTurn && (|switches), lightRndSl, lightAllSl, fini};

    always_comb begin
        winId = 2'd3;
        if (req[0])      winId = 2'd0;
        else if (req[1]) winId = 2'd1;
        else if (req[2]) winId = 2'd2;
    end

    assign winPat    = srcPat(winId, rndLed, switches);
    assign ownPat    = srcPat(grantId, rndLed, switches);
    assign lowMask   = (4'b0001 << grantId) - 4'b0001;
    assign ownReq    = req[grantId];
    assign higherReq = |(req & lowMask);
    assign failOwn   = (state == OWN) && (grantId == 2'd0);
    assign holdDone  = (state == OWN) && !failOwn && (holdCnt == HOLD_LAST)
                     && (!ownReq || higherReq);
    // With no gap configured, a finished hold arbitrates in the same edge.
    assign arbPoint  = (state == IDLE) || (state == ATTRACT)
                     || ((state == GAP) && (gapCnt == GAP_LAST))
                     || (holdDone && (GAP_CYC == 0));
    assign grantNow  = (fini && !failOwn) || (arbPoint && (|req));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            led      <= '0;
            grantVld <= 1'b0;
            grantId  <= 2'd0;
            holdCnt  <= '0;
            gapCnt   <= '0;
            blinkCnt <= '0;
            blinkOn  <= 1'b0;
            patLatch <= '0;
`ifdef SIMON_LED_ATTRACT_EN
            idleCnt   <= '0;
            attractOn <= 1'b0;
`endif
        end else if (grantNow) begin
            state    <= OWN;
            grantId  <= winId;
            grantVld <= 1'b1;
            holdCnt  <= '0;
            patLatch <= winPat;
            led      <= winPat;
            blinkCnt <= '0;
            blinkOn  <= 1'b1;
`ifdef SIMON_LED_ATTRACT_EN
            idleCnt   <= '0;
            attractOn <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    led      <= '0;
                    grantVld <= 1'b0;
`ifdef SIMON_LED_ATTRACT_EN
                    if (idleCnt == IDLE_LAST) begin
                        state     <= ATTRACT;
                        attractOn <= 1'b1;
                        led       <= N_LED'(1);
                        blinkCnt  <= '0;
                    end else begin
                        idleCnt <= idleCnt + 1'b1;
                    end
`endif
                end
                OWN: begin
                    if (failOwn) begin
                        if (blinkCnt == BLINK_LAST) begin
                            blinkCnt <= '0;
                            blinkOn  <= !blinkOn;
                            led      <= blinkOn ? '0 : ONES;
                        end else begin
                            blinkCnt <= blinkCnt + 1'b1;
                        end
                    end else if (holdDone) begin
                        led      <= '0;
                        grantVld <= 1'b0;
                        if (GAP_CYC == 0) begin
                            state <= IDLE;
`ifdef SIMON_LED_ATTRACT_EN
                            idleCnt <= '0;
`endif
                        end else begin
                            state  <= GAP;
                            gapCnt <= '0;
                        end
                    end else begin
                        if (holdCnt != HOLD_LAST) holdCnt <= holdCnt + 1'b1;
                        // Pattern follows the source only while it keeps asking.
                        if (ownReq) begin
                            patLatch <= ownPat;
                            led      <= ownPat;
                        end else begin
                            led <= patLatch;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        state <= IDLE;
`ifdef SIMON_LED_ATTRACT_EN
                        idleCnt <= '0;
`endif
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
`ifdef SIMON_LED_ATTRACT_EN
                    if (blinkCnt == BLINK_LAST) begin
                        blinkCnt <= '0;
                        led      <= {led[N_LED-2:0], led[N_LED-1]};
                    end else begin
                        blinkCnt <= blinkCnt + 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
            endcase
        end
    end

endmodule
